mdu_unit: RTL and testbench
===========================

MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL provide `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL provide `reset`, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL provide `Start`, input, 1 bit: one-cycle pulse from the E stage requesting a multiply/divide or an HI/LO write.
REQ-004 SHALL provide `Op`, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved.
REQ-005 SHALL provide `A`, input, 32 bits: forwarded rs operand from E.
REQ-006 SHALL provide `B`, input, 32 bits: forwarded rt operand from E.
REQ-007 SHALL provide `D_IsMD`, input, 1 bit: the D-stage instruction is any of MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
REQ-008 SHALL provide `Busy`, output, 1 bit: a multi-cycle operation is in flight.
REQ-009 SHALL provide `HI`, output, 32 bits: architectural HI register.
REQ-010 SHALL provide `LO`, output, 32 bits: architectural LO register.
REQ-011 SHALL provide `Stall_MD`, output, 1 bit: stall request, ORed by the pipeline stall logic into its stall term.
REQ-012 SHALL provide parameters `MULT_LAT` (default 5) and `DIV_LAT` (default 10): Busy duration in cycles.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and RUN, plus a down-counter of width ≥4 bits.
REQ-014 In IDLE, `Start` with Op 0–3 at edge k SHALL latch the computed result, load the counter with the latency, and enter RUN.
REQ-015 `Busy` SHALL be 1 for exactly `MULT_LAT` (Op 0/1) or `DIV_LAT` (Op 2/3) cycles following edge k.
REQ-016 HI/LO SHALL update at the edge where the counter reaches zero; Busy SHALL return to 0 on that same edge and the FSM SHALL return to IDLE.
REQ-017 MULT/MULTU SHALL form the signed/unsigned 64-bit product {HI,LO}.
REQ-018 DIV/DIVU SHALL write LO = quotient and HI = remainder.
REQ-019 Signed DIV SHALL truncate the quotient toward zero, and the remainder SHALL take the sign of the dividend.
REQ-020 DIV/DIVU with B = 0 SHALL still run `DIV_LAT` cycles and SHALL leave HI/LO unchanged.
REQ-021 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0.
REQ-022 MTHI/MTLO with Start in IDLE SHALL write A into HI/LO at the next edge, with Busy staying 0.
REQ-023 `Start` while Busy = 1 SHALL be ignored, with no effect on the counter or on HI/LO.
REQ-024 `Start` with a reserved Op SHALL be ignored.
REQ-025 `Stall_MD` SHALL equal D_IsMD & (Busy | (Start & Op ≤ 3)), purely combinational.
REQ-026 HI/LO SHALL be readable combinationally at any time; the values shown during RUN SHALL be the pre-operation values.

Reset
REQ-027 `reset` = 0 at an edge SHALL force IDLE, counter = 0, Busy = 0, HI = 0, LO = 0.
REQ-028 Reset SHALL abort any in-flight operation without committing its result.
REQ-029 `Start` in the same cycle as reset = 0 SHALL be ignored.

Structure
REQ-030 Op codes, `MULT_LAT`/`DIV_LAT` defaults, and FSM state encodings SHALL live in the shared package `mdu_pkg`.
REQ-031 The signed/unsigned product and quotient/remainder SHALL be computed in one combinational sub-module, `mdu_arith`.
REQ-032 `mdu_unit` SHALL hold only the FSM, the counter, the result latch, and HI/LO.

Verification
REQ-033 MULT A=0xFFFFFFFD, B=7 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-034 MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
REQ-035 DIV A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-036 Preload MTHI 0x1234, MTLO 0x5678; DIVU B=0 -> 10 busy cycles, then HI=0x1234, LO=0x5678.
REQ-037 MULT started, second Start at cycle 2 with D_IsMD=1 -> second Start ignored; Stall_MD=1 for cycles 1–5, 0 after; HI/LO hold first result only.
REQ-038 DIV started, reset=0 at cycle 4 -> Busy=0, HI=LO=0 next cycle; no later HI/LO update.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default latencies,
// FSM state encoding and the HI/LO result payload.
package mdu_pkg;

    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;
    localparam int unsigned DATA_W       = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } mdu_res_t;

endpackage

// File: rtl/mdu_arith.sv
// Combinational product / quotient-remainder datapath for the multiply/divide unit.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output mdu_res_t          res_c,
    output logic              div_zero_c
);

    logic                  is_signed;
    logic                  is_mul;
    logic                  a_neg;
    logic                  b_neg;
    logic [2*DATA_W-1:0]   a_ext;
    logic [2*DATA_W-1:0]   b_ext;
    logic [2*DATA_W-1:0]   prod;
    logic [DATA_W-1:0]     a_mag;
    logic [DATA_W-1:0]     b_mag;
    logic [DATA_W-1:0]     b_div;
    logic [DATA_W-1:0]     q_mag;
    logic [DATA_W-1:0]     r_mag;

    // Signed division goes through magnitudes so truncation toward zero and the
    // 0x80000000 / -1 corner fall out of plain unsigned arithmetic.
    always_comb begin
        is_signed  = (op == OP_MULT) || (op == OP_DIV);
        is_mul     = (op == OP_MULT) || (op == OP_MULTU);
        a_neg      = is_signed & a[DATA_W-1];
        b_neg      = is_signed & b[DATA_W-1];
        a_ext      = {{DATA_W{a_neg}}, a};
        b_ext      = {{DATA_W{b_neg}}, b};
        prod       = a_ext * b_ext;
        a_mag      = a_neg ? DATA_W'(-a) : a;
        b_mag      = b_neg ? DATA_W'(-b) : b;
        b_div      = (b_mag == '0) ? DATA_W'(1) : b_mag;
        q_mag      = a_mag / b_div;
        r_mag      = a_mag % b_div;
        div_zero_c = !is_mul && (b == '0);
        if (is_mul) begin
            res_c.hi = prod[2*DATA_W-1:DATA_W];
            res_c.lo = prod[DATA_W-1:0];
        end else begin
            res_c.hi = a_neg ? DATA_W'(-r_mag) : r_mag;
            res_c.lo = (a_neg ^ b_neg) ? DATA_W'(-q_mag) : q_mag;
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit: latches the result at issue, holds Busy for a fixed
// latency, then commits to HI/LO.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic [2:0]        Op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              D_IsMD,
    output logic              Busy,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO,
    output logic              Stall_MD
);

    localparam int unsigned LAT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = ($clog2(LAT_MAX + 1) < 4) ? 4 : $clog2(LAT_MAX + 1);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mdu_res_t          res_q, res_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    mdu_res_t          arith_res;
    logic              arith_div_zero;
    logic              start_md;
    logic              is_mul_op;

    mdu_arith u_arith (
        .op         (Op),
        .a          (A),
        .b          (B),
        .res_c      (arith_res),
        .div_zero_c (arith_div_zero)
    );

    assign start_md  = Start & (Op[2] == 1'b0);
    assign is_mul_op = (Op[2:1] == 2'b00);

    // Next-state, counter and HI/LO update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        wr_d    = wr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start_md) begin
                    res_d   = arith_res;
                    wr_d    = !arith_div_zero;
                    cnt_d   = is_mul_op ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
                    state_d = ST_RUN;
                end else if (Start && (Op == OP_MTHI)) begin
                    hi_d = A;
                end else if (Start && (Op == OP_MTLO)) begin
                    lo_d = A;
                end
            end
            ST_RUN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (wr_q) begin
                        hi_d = res_q.hi;
                        lo_d = res_q.lo;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            wr_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            wr_q    <= wr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy     = (state_q == ST_RUN);
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign Stall_MD = D_IsMD & (Busy | start_md);

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed scenarios plus randomized traffic
// compared against a cycle-level arithmetic reference model.
module tb_mdu_unit;

    localparam int unsigned MULT_LAT = 5;
    localparam int unsigned DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        D_IsMD = 1'b0;
    logic        Busy;
    logic        Stall_MD;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_cnt = 0;
    string phase = "init";

    // Reference model state
    int          m_left = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;
    logic        p_wr = 1'b0;

    always #5 clk = ~clk;

    mdu_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .Start    (Start),
        .Op       (Op),
        .A        (A),
        .B        (B),
        .D_IsMD   (D_IsMD),
        .Busy     (Busy),
        .HI       (HI),
        .LO       (LO),
        .Stall_MD (Stall_MD)
    );

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural behaviour at one rising edge, from plain 64-bit arithmetic
    task automatic model_edge(input logic rst_n, input logic st, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (!rst_n) begin
            m_left = 0; m_hi = 32'd0; m_lo = 32'd0; p_wr = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_wr) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (st) begin
            case (op)
                3'd0: begin
                    sp = sa * sb; p_hi = sp[63:32]; p_lo = sp[31:0];
                    p_wr = 1'b1; m_left = MULT_LAT;
                end
                3'd1: begin
                    up = ua * ub; p_hi = up[63:32]; p_lo = up[31:0];
                    p_wr = 1'b1; m_left = MULT_LAT;
                end
                3'd2: begin
                    p_wr = (b != 32'd0); m_left = DIV_LAT;
                    if (p_wr) begin
                        sq = sa / sb; sr = sa % sb; p_lo = sq[31:0]; p_hi = sr[31:0];
                    end
                end
                3'd3: begin
                    p_wr = (b != 32'd0); m_left = DIV_LAT;
                    if (p_wr) begin
                        up = ua / ub; p_lo = up[31:0];
                        up = ua % ub; p_hi = up[31:0];
                    end
                end
                3'd4: m_hi = a;
                3'd5: m_lo = a;
                default: ;
            endcase
        end
    endtask

    // One clock cycle: drive, check pre-edge outputs at negedge, advance the model
    task automatic cycle(input logic rst_n, input logic st, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic dmd);
        logic exp_stall;
        reset = rst_n; Start = st; Op = op; A = a; B = b; D_IsMD = dmd;
        @(negedge clk);
        exp_stall = dmd & ((m_left > 0) | (st & (op <= 3'd3)));
        check32({phase, ".busy"},  32'(Busy),     32'(m_left > 0));
        check32({phase, ".stall"}, 32'(Stall_MD), 32'(exp_stall));
        check32({phase, ".hi"},    HI, m_hi);
        check32({phase, ".lo"},    LO, m_lo);
        if (Busy) busy_cnt++;
        @(posedge clk);
        model_edge(rst_n, st, op, a, b);
        #1;
    endtask

    task automatic idle(input int n, input logic dmd);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, dmd);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'(($urandom_range(0, 20)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        @(posedge clk); #1;
        phase = "reset";
        cycle(1'b0, 1'b1, 3'd0, 32'd3, 32'd4, 1'b0);
        check32("reset.hi0", HI, 32'd0);
        check32("reset.busy0", 32'(Busy), 32'd0);

        phase = "mult";
        busy_cnt = 0;
        cycle(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        idle(6, 1'b0);
        check32("mult.busy_cycles", 32'(busy_cnt), 32'd5);
        check32("mult.hi", HI, 32'hFFFF_FFFF);
        check32("mult.lo", LO, 32'hFFFF_FFEB);

        phase = "multu";
        cycle(1'b1, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        idle(5, 1'b0);
        check32("multu.hi", HI, 32'h0000_0001);
        check32("multu.lo", LO, 32'hFFFF_FFFE);

        phase = "div";
        busy_cnt = 0;
        cycle(1'b1, 1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(11, 1'b0);
        check32("div.busy_cycles", 32'(busy_cnt), 32'd10);
        check32("div.lo", LO, 32'hFFFF_FFFD);
        check32("div.hi", HI, 32'hFFFF_FFFF);

        phase = "divz";
        busy_cnt = 0;
        cycle(1'b1, 1'b1, 3'd4, 32'h1234, 32'd0, 1'b0);
        cycle(1'b1, 1'b1, 3'd5, 32'h5678, 32'd0, 1'b0);
        check32("mt.busy_cycles", 32'(busy_cnt), 32'd0);
        cycle(1'b1, 1'b1, 3'd3, 32'd99, 32'd0, 1'b0);
        idle(11, 1'b0);
        check32("divz.busy_cycles", 32'(busy_cnt), 32'd10);
        check32("divz.hi", HI, 32'h1234);
        check32("divz.lo", LO, 32'h5678);

        phase = "overlap";
        cycle(1'b1, 1'b1, 3'd0, 32'd6, 32'd7, 1'b1);
        cycle(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        cycle(1'b1, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        idle(5, 1'b1);
        check32("overlap.hi", HI, 32'd0);
        check32("overlap.lo", LO, 32'd42);
        check32("overlap.stall_after", 32'(Stall_MD), 32'd0);

        phase = "divovf";
        cycle(1'b1, 1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(10, 1'b0);
        check32("divovf.lo", LO, 32'h8000_0000);
        check32("divovf.hi", HI, 32'd0);

        phase = "abort";
        cycle(1'b1, 1'b1, 3'd4, 32'hAAAA, 32'd0, 1'b0);
        cycle(1'b1, 1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
        idle(3, 1'b0);
        cycle(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        check32("abort.busy", 32'(Busy), 32'd0);
        check32("abort.hi", HI, 32'd0);
        check32("abort.lo", LO, 32'd0);
        idle(12, 1'b0);

        phase = "rsvd";
        cycle(1'b1, 1'b1, 3'd6, 32'd5, 32'd5, 1'b1);
        cycle(1'b1, 1'b1, 3'd7, 32'd5, 32'd5, 1'b1);
        idle(1, 1'b0);

        phase = "rnd";
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 60) != 0), ($urandom_range(0, 3) == 0),
                  3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
        end
        idle(12, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
